// File: rtl/ask_pkg.sv
// ask_pkg: shared 2ASK link constants and decoder state type, common to modulator and demodulator.
package ask_pkg;
  typedef enum logic {IDLE, TRACK} state_t;
  localparam int DEF_CARRIER_HALF = 2;
  localparam int DEF_SYM_LEN = 16;
endpackage

// File: rtl/ask_env_det.sv
// ask_env_det: synchronizes the ASK line, flags transitions and tracks the carrier envelope.
module ask_env_det
  import ask_pkg::*;
#(
  parameter int CARRIER_HALF = DEF_CARRIER_HALF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ask_in,
  output logic ask_edge,
  output logic env_out,
  output logic env_rise
);
  localparam int HOLD = 2 * CARRIER_HALF + 1;
  localparam int HW = $clog2(HOLD + 1);
  logic ask_m, ask_s, ask_d;
  logic [HW-1:0] hold_cnt, hold_nxt;
  assign ask_edge = ask_s ^ ask_d;
  assign hold_nxt = ask_edge ? '0 : (hold_cnt == HW'(HOLD)) ? hold_cnt : hold_cnt + 1'b1;
  // envelope only rises on a real edge, so a fresh reset never reports carrier
  assign env_rise = ask_edge & ~env_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ask_m <= 1'b0;
      ask_s <= 1'b0;
      ask_d <= 1'b0;
      hold_cnt <= '0;
      env_out <= 1'b0;
    end else begin
      ask_m <= ask_in;
      ask_s <= ask_m;
      ask_d <= ask_s;
      hold_cnt <= hold_nxt;
      env_out <= ask_edge | (env_out & (hold_nxt < HW'(HOLD)));
    end
endmodule

// File: rtl/ask_decode.sv
// ask_decode: 2ASK demodulator; counts carrier edges per symbol window and emits one decided bit per symbol.
module ask_decode
  import ask_pkg::*;
#(
  parameter int CARRIER_HALF = DEF_CARRIER_HALF,
  parameter int SYM_LEN = DEF_SYM_LEN,
  parameter int MIN_EDGES = 3,
  parameter int IDLE_SYMS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ask_in,
  output logic data_out,
  output logic data_valid,
  output logic env_out,
  output logic locked
);
  localparam int SW = $clog2(SYM_LEN);
  localparam int EW = $clog2(MIN_EDGES + 1);
  localparam int ZW = $clog2(IDLE_SYMS + 1);
  state_t state, state_n;
  logic [SW-1:0] sym_cnt, sym_n;
  logic [EW-1:0] edge_cnt, edge_n;
  logic [EW:0] edge_tot;
  logic [ZW-1:0] zero_run, zero_n;
  logic ask_edge, env_rise, wrap, restart, emit, bit_dec, drop, data_n;
  ask_env_det #(.CARRIER_HALF(CARRIER_HALF)) u_env (
    .clk(clk),
    .rst_n(rst_n),
    .ask_in(ask_in),
    .ask_edge(ask_edge),
    .env_out(env_out),
    .env_rise(env_rise)
  );
  assign edge_tot = {1'b0, edge_cnt} + {{EW{1'b0}}, ask_edge};
  always_comb begin
    wrap = sym_cnt == SW'(SYM_LEN - 1);
    bit_dec = edge_tot >= (EW + 1)'(MIN_EDGES);
    // a late carrier restart closes the running symbol; an early one just realigns
    emit = state == TRACK && (env_rise ? sym_cnt >= SW'(SYM_LEN / 2) : wrap);
    drop = emit && !bit_dec && zero_run == ZW'(IDLE_SYMS - 1);
    restart = state == IDLE || env_rise;
    state_n = state == IDLE ? (ask_edge ? TRACK : IDLE) : (drop ? IDLE : TRACK);
    sym_n = state_n == IDLE ? '0 : restart ? SW'(1) : wrap ? '0 : sym_cnt + 1'b1;
    edge_n = state_n == IDLE ? '0 : restart ? EW'(1) : wrap ? '0 : bit_dec ? EW'(MIN_EDGES) : edge_tot[EW-1:0];
    zero_n = state_n == IDLE ? '0 : !emit ? zero_run : bit_dec ? '0 : zero_run + 1'b1;
    data_n = emit ? bit_dec : data_out;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sym_cnt <= '0;
      edge_cnt <= '0;
      zero_run <= '0;
      data_out <= 1'b0;
      data_valid <= 1'b0;
      locked <= 1'b0;
    end else begin
      state <= state_n;
      sym_cnt <= sym_n;
      edge_cnt <= edge_n;
      zero_run <= zero_n;
      data_out <= data_n;
      data_valid <= emit;
      locked <= state == TRACK;
    end
endmodule
